// File: rtl/regaccess_pkg.sv
// Shared definitions for the register-access SPI master: field widths,
// FSM state encoding and small constant helpers.
package regaccess_pkg;

    localparam int RA_WE_BIT   = 7;
    localparam int RA_REGNUM_W = 7;
    localparam int RA_DATA_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT0,
        GAP,
        SHIFT1,
        HOLD,
        SSGAP
    } ra_state_e;

    // Largest of three timing parameters; sizes the shared phase counter.
    function automatic int ra_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Command byte sent first in every transaction: write flag over register number.
    function automatic logic [RA_DATA_W-1:0] ra_cmd_byte(input logic we,
                                                         input logic [RA_REGNUM_W-1:0] regnum);
        logic [RA_DATA_W-1:0] b;
        b = '0;
        b[RA_REGNUM_W-1:0] = regnum;
        b[RA_WE_BIT] = we;
        return b;
    endfunction

endpackage

// File: rtl/regaccess_master_if.sv
// Request/response handshake between a register-access client and the SPI master.
interface regaccess_master_if import regaccess_pkg::*; ();

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [RA_REGNUM_W-1:0] req_regnum;
    logic [RA_DATA_W-1:0]   req_wdata;
    logic                   rsp_valid;
    logic [RA_DATA_W-1:0]   rsp_rdata;
    logic                   busy;

    // Client side: issues requests, receives completions.
    modport master (
        output req_valid, req_write, req_regnum, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    // SPI engine side: accepts requests, reports completions.
    modport slave (
        input  req_valid, req_write, req_regnum, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );

endinterface

// File: rtl/spi_master_byte.sv
// One-byte SPI mode-0 shifter: CLK_DIV cycles sck low, CLK_DIV high per bit,
// MSB first, miso sampled as sck rises. done flags the final clk cycle of the byte.
module spi_master_byte import regaccess_pkg::*; #(
    parameter int CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [RA_DATA_W-1:0] tx_byte,
    input  logic                 miso,
    output logic                 sck,
    output logic                 mosi,
    output logic                 done,
    output logic [RA_DATA_W-1:0] rx_byte
);

    localparam int CW = $clog2(CLK_DIV);

    logic                 active;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_cnt;
    logic [RA_DATA_W-1:0] tx_sh;
    logic                 phase_end;

    assign phase_end = active && (cnt == CW'(CLK_DIV - 1));
    assign done      = phase_end && sck && (bit_cnt == 3'd7);
    assign mosi      = tx_sh[RA_DATA_W-1];

    // Half-period timing, sck toggling, miso capture on rise and mosi shift on fall.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            active  <= 1'b0;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            sck     <= 1'b0;
            rx_byte <= '0;
        end else if (start) begin
            active  <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sh   <= tx_byte;
            sck     <= 1'b0;
        end else if (phase_end) begin
            cnt <= '0;
            if (!sck) begin
                sck     <= 1'b1;
                rx_byte <= {rx_byte[RA_DATA_W-2:0], miso};
            end else begin
                sck <= 1'b0;
                if (bit_cnt == 3'd7) begin
                    active <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                    tx_sh   <= {tx_sh[RA_DATA_W-2:0], 1'b0};
                end
            end
        end else if (active) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regaccess_master.sv
// Register-access SPI master: turns one request into a two-byte SPI
// transaction (command byte, data byte) inside a single ss-low window.
module regaccess_master import regaccess_pkg::*; #(
    parameter int CLK_DIV  = 4,
    parameter int BYTE_GAP = 8,
    parameter int SS_GAP   = 8
) (
    input  logic               clk,
    input  logic               rst,
    regaccess_master_if.slave  bus,
    output logic               ss,
    output logic               sck,
    output logic               mosi,
    input  logic               miso
);

    localparam int CNT_MAX = ra_max3(CLK_DIV, BYTE_GAP, SS_GAP);
    localparam int CW      = $clog2(CNT_MAX + 1);

    ra_state_e            state, state_nx;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        phase_last;
    logic                 phase_done;
    logic                 timed_state;
    logic                 accept;
    logic                 is_write;
    logic [RA_DATA_W-1:0] tx0, tx1;
    logic                 spi_start, spi_mosi, spi_done;
    logic [RA_DATA_W-1:0] spi_tx, spi_rx;
    logic                 rsp_fire;

    assign accept      = (state == IDLE) && bus.req_valid;
    assign timed_state = (state == SETUP) || (state == GAP) || (state == HOLD) || (state == SSGAP);
    assign phase_done  = (cnt == phase_last);
    assign rsp_fire    = (state == HOLD) && phase_done;
    assign spi_tx      = (state == GAP) ? tx1 : tx0;

    assign bus.busy      = (state != IDLE);
    assign bus.req_ready = (state == IDLE);
    assign ss            = (state == IDLE) || (state == SSGAP);

    spi_master_byte #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk     (clk),
        .rst     (rst),
        .start   (spi_start),
        .tx_byte (spi_tx),
        .miso    (miso),
        .sck     (sck),
        .mosi    (spi_mosi),
        .done    (spi_done),
        .rx_byte (spi_rx)
    );

    // Next-state logic: fixed-length phases plus the two shifter-driven bytes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nx   = state;
        spi_start  = 1'b0;
        phase_last = '0;
        case (state)
            IDLE:   if (bus.req_valid) state_nx = SETUP;
            SETUP: begin
                phase_last = CW'(CLK_DIV - 1);
                if (phase_done) begin
                    state_nx  = SHIFT0;
                    spi_start = 1'b1;
                end
            end
            SHIFT0: if (spi_done) state_nx = GAP;
            GAP: begin
                phase_last = CW'(BYTE_GAP - 1);
                if (phase_done) begin
                    state_nx  = SHIFT1;
                    spi_start = 1'b1;
                end
            end
            SHIFT1: if (spi_done) state_nx = HOLD;
            HOLD: begin
                phase_last = CW'(CLK_DIV - 1);
                if (phase_done) state_nx = SSGAP;
            end
            SSGAP: begin
                phase_last = CW'(SS_GAP - 1);
                if (phase_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // mosi follows the staged byte outside the shifter and is forced low while ss is high.
    always_comb begin
        mosi = 1'b0;
        case (state)
            SETUP:          mosi = tx0[RA_DATA_W-1];
            SHIFT0, SHIFT1: mosi = spi_mosi;
            GAP:            mosi = tx1[RA_DATA_W-1];
            default:        mosi = 1'b0;
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Phase counter restarts on every state change and only runs in fixed-length phases.
    always_ff @(posedge clk) begin
        if (rst || (state_nx != state)) cnt <= '0;
        else if (timed_state)           cnt <= cnt + 1'b1;
    end

    // Capture the request on acceptance so later bus activity cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_write <= 1'b0;
            tx0      <= '0;
            tx1      <= '0;
        end else if (accept) begin
            is_write <= bus.req_write;
            tx0      <= ra_cmd_byte(bus.req_write, bus.req_regnum);
            tx1      <= bus.req_write ? bus.req_wdata : '0;
        end
    end

    // Completion pulse lands on the cycle ss rises; read data comes from byte 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= rsp_fire;
            if (rsp_fire) bus.rsp_rdata <= is_write ? '0 : spi_rx;
        end
    end

endmodule

// File: tb/tb_regaccess_master.sv
// Self-checking bench for regaccess_master: SPI register-slave model,
// window timing monitor and randomized register traffic against a reference memory.
module tb_regaccess_master;

    localparam int CD = 4;
    localparam int BG = 8;
    localparam int SG = 8;
    localparam int WIN_LEN = CD + 16 * CD + BG + 16 * CD + CD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss, sck, mosi;
    logic miso = 1'b0;

    regaccess_master_if bus ();

    regaccess_master #(.CLK_DIV(CD), .BYTE_GAP(BG), .SS_GAP(SG)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .ss   (ss),
        .sck  (sck),
        .mosi (mosi),
        .miso (miso)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Register file seen by the SPI slave and the bench's own expectation of it.
    logic [7:0] slv_mem [128];
    logic [7:0] ref_mem [128];

    // SPI slave model: byte 0 = {we, regnum}, byte 1 = data (write) or read data out.
    int          slv_bits = 0;
    logic [15:0] slv_sh   = '0;
    logic [7:0]  slv_rd   = '0;
    logic [7:0]  slv_b0_q [$];
    logic [7:0]  slv_b1_q [$];

    always @(negedge ss) begin
        slv_bits = 0;
        miso     = 1'($urandom);
    end

    always @(posedge sck) begin
        if (ss === 1'b0) begin
            slv_sh = {slv_sh[14:0], mosi};
            slv_bits++;
            if (slv_bits == 8) slv_rd = slv_mem[slv_sh[6:0]];
            if (slv_bits == 16) begin
                slv_b0_q.push_back(slv_sh[15:8]);
                slv_b1_q.push_back(slv_sh[7:0]);
                if (slv_sh[15]) slv_mem[slv_sh[14:8]] = slv_sh[7:0];
            end
        end
    end

    always @(negedge sck) begin
        if (ss === 1'b0) begin
            if (slv_bits >= 8 && slv_bits < 16) miso = slv_rd[15 - slv_bits];
            else                                 miso = 1'($urandom);
        end
    end

    // Monitor: sck run lengths per ss-low window, ss-high gaps, idle pin levels, rsp pulses.
    int         rsp_count  = 0;
    logic [7:0] rsp_q [$];
    bit         abort_flag = 0;
    int         win_len = 0, cur_len = 0, hi_len = 0, last_gap = 0, idle_viol = 0;
    bit         cur_lvl = 0, prev_ss = 1, prev_rsp = 0;
    int         runs [$];
    int         exp_runs [$];

    initial begin
        exp_runs.push_back(-2 * CD);
        exp_runs.push_back(CD);
        for (int i = 0; i < 7; i++) begin exp_runs.push_back(-CD); exp_runs.push_back(CD); end
        exp_runs.push_back(-(BG + CD));
        exp_runs.push_back(CD);
        for (int i = 0; i < 7; i++) begin exp_runs.push_back(-CD); exp_runs.push_back(CD); end
        exp_runs.push_back(-CD);
    end

    always @(negedge clk) begin
        if (ss === 1'b0) begin
            if (prev_ss) begin
                last_gap = hi_len;
                runs.delete();
                win_len = 1;
                cur_lvl = (sck === 1'b1);
                cur_len = 1;
            end else begin
                win_len++;
                if ((sck === 1'b1) == cur_lvl) cur_len++;
                else begin
                    runs.push_back(cur_lvl ? cur_len : -cur_len);
                    cur_lvl = (sck === 1'b1);
                    cur_len = 1;
                end
            end
        end else begin
            if (!prev_ss) begin
                runs.push_back(cur_lvl ? cur_len : -cur_len);
                hi_len = 0;
                if (!abort_flag) begin
                    bit ok;
                    int bad;
                    ok  = (win_len == WIN_LEN) && (runs.size() == exp_runs.size());
                    bad = -1;
                    if (ok) for (int i = 0; i < runs.size(); i++)
                        if (runs[i] != exp_runs[i] && bad < 0) bad = i;
                    n_cmp++;
                    if (!ok || bad >= 0) begin
                        n_err++;
                        $display("FAIL window_timing: got len %0d runs %0d first_bad_run %0d, need len %0d runs %0d",
                                 win_len, runs.size(), bad, WIN_LEN, exp_runs.size());
                    end
                end
                abort_flag = 0;
            end
            hi_len++;
            if (mosi !== 1'b0 || sck !== 1'b0) idle_viol++;
        end
        if (bus.rsp_valid === 1'b1) begin
            rsp_count++;
            rsp_q.push_back(bus.rsp_rdata);
            n_cmp++;
            if (!(ss === 1'b1 && !prev_ss && !prev_rsp)) begin
                n_err++;
                $display("FAIL rsp_pulse_timing: got ss=%b prev_ss=%b prev_rsp=%b, need 1 0 0", ss, prev_ss, prev_rsp);
            end
        end
        prev_ss  = (ss !== 1'b0);
        prev_rsp = (bus.rsp_valid === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic accept(input bit w, input logic [6:0] rn, input logic [7:0] wd, output bit ok);
        int k;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_regnum = rn;
        bus.req_wdata  = wd;
        k = 0;
        while (bus.req_ready !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
        ok = (k < 2000);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL accept_timeout: waited %0d cycles, need ready within 2000", k);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'($urandom);
        bus.req_regnum = 7'($urandom);
        bus.req_wdata  = 8'($urandom);
        n_cmp++;
        if ({ss, bus.busy, bus.req_ready} !== 3'b010) begin
            n_err++;
            $display("FAIL accept_ss_fall: got ss/busy/ready=%b, need 010", {ss, bus.busy, bus.req_ready});
        end
    endtask

    task automatic wait_rsp(input int target, input string tag);
        int k;
        k = 0;
        while (rsp_count < target && k < 3000) begin @(negedge clk); k++; end
        n_cmp++;
        if (rsp_count < target) begin
            n_err++;
            $display("FAIL %s rsp_timeout: got %0d responses, need %0d", tag, rsp_count, target);
        end
    endtask

    task automatic check_bytes(input logic [7:0] e0, input logic [7:0] e1, input string tag);
        logic [7:0] b0, b1;
        b0 = 8'hxx;
        b1 = 8'hxx;
        if (slv_b0_q.size() > 0) begin b0 = slv_b0_q.pop_front(); b1 = slv_b1_q.pop_front(); end
        n_cmp++;
        if (b0 !== e0 || b1 !== e1) begin
            n_err++;
            $display("FAIL %s mosi_bytes: got %h %h, need %h %h", tag, b0, b1, e0, e1);
        end
    endtask

    task automatic check_rdata(input logic [7:0] e, input string tag);
        logic [7:0] got;
        got = 8'hxx;
        if (rsp_q.size() > 0) got = rsp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s rsp_rdata: got %h, need %h", tag, got, e);
        end
    endtask

    task automatic run_txn(input bit w, input logic [6:0] rn, input logic [7:0] wd, input string tag);
        int         rc0;
        bit         ok;
        logic [7:0] exp_rd;
        rc0    = rsp_count;
        exp_rd = w ? 8'h00 : ref_mem[rn];
        if (w) ref_mem[rn] = wd;
        accept(w, rn, wd, ok);
        if (!ok) return;
        wait_rsp(rc0 + 1, tag);
        check_rdata(exp_rd, tag);
        check_bytes({w, rn}, w ? wd : 8'h00, tag);
        repeat (SG + 4) @(negedge clk);
        n_cmp++;
        if (rsp_count != rc0 + 1) begin
            n_err++;
            $display("FAIL %s rsp_count: got %0d pulses, need 1", tag, rsp_count - rc0);
        end
        if (w) begin
            n_cmp++;
            if (slv_mem[rn] !== wd) begin
                n_err++;
                $display("FAIL %s slave_reg: got %h, need %h", tag, slv_mem[rn], wd);
            end
        end
    endtask

    task automatic test_reset();
        logic [13:0] got;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        got = {ss, sck, mosi, bus.busy, bus.req_ready, bus.rsp_valid, bus.rsp_rdata};
        n_cmp++;
        if (got !== {6'b100010, 8'h00}) begin
            n_err++;
            $display("FAIL reset_state: got %b, need %b", got, {6'b100010, 8'h00});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        got = {ss, sck, mosi, bus.busy, bus.req_ready, bus.rsp_valid, bus.rsp_rdata};
        n_cmp++;
        if (got !== {6'b100010, 8'h00}) begin
            n_err++;
            $display("FAIL post_reset_idle: got %b, need %b", got, {6'b100010, 8'h00});
        end
    endtask

    task automatic test_basic();
        run_txn(1'b1, 7'h12, 8'hA5, "write_12");
        slv_mem[7'h05] = 8'h3C; ref_mem[7'h05] = 8'h3C;
        run_txn(1'b0, 7'h05, 8'h00, "read_05");
    endtask

    task automatic test_boundary();
        slv_mem[7'h7F] = 8'hFF; ref_mem[7'h7F] = 8'hFF;
        slv_mem[7'h00] = 8'h00; ref_mem[7'h00] = 8'h00;
        run_txn(1'b0, 7'h7F, 8'h00, "read_7f");
        run_txn(1'b0, 7'h00, 8'h00, "read_00");
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++)
            run_txn(1'($urandom), 7'($urandom), 8'($urandom), "random");
    endtask

    task automatic test_back_to_back();
        logic [6:0] rn;
        logic [7:0] wa;
        int         rc0, cyc, t_rsp, t_acc;
        rn  = 7'($urandom);
        wa  = 8'($urandom);
        rc0 = rsp_count;
        ref_mem[rn] = wa;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_regnum = rn; bus.req_wdata = wa;
        cyc = 0;
        while (bus.req_ready !== 1'b1 && cyc < 2000) begin @(negedge clk); cyc++; end
        @(posedge clk);
        @(negedge clk);
        bus.req_write = 1'b0; bus.req_regnum = rn; bus.req_wdata = ~wa;
        cyc = 0; t_rsp = -1; t_acc = -1;
        while (cyc < 3000 && t_acc < 0) begin
            if (bus.rsp_valid === 1'b1 && t_rsp < 0) t_rsp = cyc;
            if (bus.req_ready === 1'b1) t_acc = cyc;
            else begin @(negedge clk); cyc++; end
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_cmp++;
        if (t_rsp < 0 || t_acc < 0 || t_acc - t_rsp != SG) begin
            n_err++;
            $display("FAIL b2b_spacing: got rsp@%0d accept@%0d, need accept %0d cycles after rsp", t_rsp, t_acc, SG);
        end
        wait_rsp(rc0 + 2, "b2b");
        check_rdata(8'h00, "b2b_first");
        check_rdata(wa, "b2b_second");
        check_bytes({1'b1, rn}, wa, "b2b_first");
        check_bytes({1'b0, rn}, 8'h00, "b2b_second");
        n_cmp++;
        if (last_gap < SG) begin
            n_err++;
            $display("FAIL b2b_ss_gap: got %0d ss-high cycles, need >= %0d", last_gap, SG);
        end
        repeat (SG + 4) @(negedge clk);
    endtask

    task automatic test_abort();
        logic [6:0] rn;
        int         rc0, q0, k;
        bit         ok;
        logic [11:0] got;
        rn  = 7'($urandom);
        rc0 = rsp_count;
        q0  = slv_b0_q.size();
        accept(1'b0, rn, 8'h00, ok);
        k = 0;
        while (slv_bits < 12 && k < 2000) begin @(negedge clk); k++; end
        n_cmp++;
        if (slv_bits < 12) begin
            n_err++;
            $display("FAIL abort_reach_bit: got %0d sck rises, need 12", slv_bits);
        end
        abort_flag = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        got = {ss, sck, mosi, bus.busy, bus.rsp_valid, bus.rsp_rdata[6:0]};
        n_cmp++;
        if (got !== 12'b100000000000) begin
            n_err++;
            $display("FAIL abort_next_cycle: got %b, need 100000000000", got);
        end
        rst = 1'b0;
        repeat (200) @(negedge clk);
        n_cmp++;
        if (rsp_count != rc0 || slv_b0_q.size() != q0) begin
            n_err++;
            $display("FAIL abort_no_rsp: got %0d pulses %0d slave txns, need 0 0", rsp_count - rc0, slv_b0_q.size() - q0);
        end
        run_txn(1'b0, 7'($urandom), 8'h00, "post_abort_read");
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            slv_mem[i] = 8'($urandom);
            ref_mem[i] = slv_mem[i];
        end
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_regnum = '0;
        bus.req_wdata  = '0;

        test_reset();
        test_basic();
        test_boundary();
        test_random();
        test_back_to_back();
        test_abort();

        n_cmp++;
        if (idle_viol != 0) begin
            n_err++;
            $display("FAIL idle_pins: got %0d cycles with mosi/sck high while ss high, need 0", idle_viol);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regaccess_master.md
REGACCESS_MASTER -- requirements
Module: regaccess_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCK half-period, min 2.
REQ-002 SHALL have parameter BYTE_GAP, default 8: clk cycles of SCK-low idle between byte 0 and byte 1, min 1.
REQ-003 SHALL have parameter SS_GAP, default 8: clk cycles ss held high after a transaction before the next may start, min 1.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  1  request offered.
REQ-007 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-008 req_write  in  1  1=register write, 0=register read.
REQ-009 req_regnum  in  7  register number.
REQ-010 req_wdata  in  8  write data, ignored for reads.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  8  read data, valid with rsp_valid; 0 for writes.
REQ-013 busy  out  1  high from acceptance until SS_GAP expires.
REQ-014 ss  out  1  SPI slave select, active-low.
REQ-015 sck  out  1  SPI clock, idle low (mode 0).
REQ-016 mosi  out  1  SPI data out, MSB first.
REQ-017 miso  in  1  SPI data in, sampled on SCK rising edge.

Function
REQ-018 req_ready SHALL equal !busy; request fields SHALL be captured on acceptance and held internally.
REQ-019 Each transaction SHALL be exactly two bytes in one ss-low window: byte 0 = {req_write, req_regnum}; byte 1 = req_wdata for writes, 8'h00 for reads.
REQ-020 For reads, rsp_rdata SHALL be the 8 bits sampled on miso during byte 1; byte-0 miso SHALL be discarded.
REQ-021 FSM states: IDLE, SETUP, SHIFT0, GAP, SHIFT1, HOLD, SSGAP.
REQ-022 IDLE->SETUP on acceptance; ss SHALL fall the cycle after acceptance; mosi SHALL present bit 7 of byte 0.
REQ-023 SETUP SHALL last CLK_DIV cycles, then SHIFT0.
REQ-024 SHIFT: 8 bits; each bit = CLK_DIV cycles sck low then CLK_DIV cycles sck high; miso sampled at the sck rising transition; mosi updated at the sck falling transition to the next bit.
REQ-025 SHIFT0->GAP after the 8th high phase; sck low for BYTE_GAP cycles with mosi = bit 7 of byte 1; then SHIFT1.
REQ-026 SHIFT1->HOLD after the 8th high phase; sck low for CLK_DIV cycles, then ss rises and state goes to SSGAP.
REQ-027 rsp_valid SHALL pulse exactly one cycle, on the cycle ss rises.
REQ-028 SSGAP SHALL hold ss high, sck low for SS_GAP cycles, then IDLE; busy falls on entry to IDLE.
REQ-029 A req_valid during busy SHALL be ignored with no side effect; back-to-back requests are spaced by the full SSGAP.
REQ-030 Counters SHALL be sized to hold max(CLK_DIV, BYTE_GAP, SS_GAP) and SHALL not wrap within a phase.
REQ-031 mosi SHALL be 0 whenever ss is high.

Reset
REQ-032 On rst, state SHALL become IDLE within one cycle: ss=1, sck=0, mosi=0, busy=0, req_ready=1, rsp_valid=0, rsp_rdata=0.
REQ-033 rst mid-transaction SHALL abort immediately (ss high next cycle), emit no rsp_valid, and discard captured request.

Structure
REQ-034 Shared package regaccess_pkg SHALL hold: RA_WE_BIT=7, RA_REGNUM_W=7, RA_DATA_W=8, FSM state encoding.
REQ-035 One sub-module spi_master_byte (8-bit mode-0 shifter with start/done, CLK_DIV param) SHALL do SHIFT0/SHIFT1; the top FSM sequences it.

Verification
REQ-036 Write regnum 7'h12 data 8'hA5 -> mosi bytes 8'h92, 8'hA5; slave model writes reg 0x12=0xA5; one rsp_valid, rsp_rdata=0.
REQ-037 Read regnum 7'h05 with slave reg 0x05=0x3C -> mosi bytes 8'h05, 8'h00; rsp_rdata=8'h3C.
REQ-038 CLK_DIV=4: each sck high and low phase exactly 4 clk cycles; GAP exactly BYTE_GAP cycles; ss low window exactly 4+64+8+64+4 = 144 cycles.
REQ-039 Hold req_valid high with two queued requests -> second accepted only after SS_GAP; ss high >= SS_GAP cycles between windows.
REQ-040 Assert rst during SHIFT1 bit 3 -> ss=1, sck=0 next cycle; no rsp_valid; next read completes correctly.
REQ-041 Read regnum 7'h7F with slave returning 8'hFF, then regnum 7'h00 with 8'h00 -> rsp_rdata 8'hFF then 8'h00 (bit-order and boundary values).
